// File: rtl/axis_avg_pkg.sv
// Shared types and config-field layout for the decimating averager.
package axis_avg_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } avg_state_e;

    localparam int unsigned LOG2N_LSB  = 0;
    localparam int unsigned LOG2N_W    = 4;
    localparam int unsigned ENABLE_BIT = 8;
    localparam int unsigned CLR_BIT    = 9;
    localparam int unsigned DROP_CNT_W = 16;
    localparam int unsigned WIN_CNT_W  = 16;
    localparam int unsigned CFG_ADDR_W = 32;
    localparam int unsigned CFG_DATA_W = 512;

    typedef struct packed {
        logic               clr;
        logic               enable;
        logic [LOG2N_W-1:0] log2n;
    } avg_cfg_t;

    // Decode the low config-word fields, clamping the exponent to the build maximum.
    function automatic avg_cfg_t decode_cfg(input logic [CLR_BIT:0] data,
                                            input int unsigned max_log2n);
        avg_cfg_t           c;
        logic [LOG2N_W-1:0] raw;
        raw      = data[LOG2N_LSB +: LOG2N_W];
        c.log2n  = (32'(raw) > max_log2n) ? LOG2N_W'(max_log2n) : raw;
        c.enable = data[ENABLE_BIT];
        c.clr    = data[CLR_BIT];
        return c;
    endfunction

endpackage

// File: rtl/axis_decimating_averager_if.sv
// AXI-Stream bundle for the averager. AXIS_AVG_MINMAX_EN adds min/max sidebands.
interface axis_decimating_averager_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned AUX_W  = 32
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
`ifdef AXIS_AVG_MINMAX_EN
    logic [AUX_W-1:0]  min_tdata;
    logic [AUX_W-1:0]  max_tdata;
`endif

    // Producer side with backpressure.
    modport master (
        output tdata,
        output tvalid,
`ifdef AXIS_AVG_MINMAX_EN
        output min_tdata,
        output max_tdata,
`endif
        input  tready
    );

    // Consumer side of a stream that cannot be stalled.
    modport sink (
        input tdata,
        input tvalid
    );
endinterface

// File: rtl/axis_out_reg.sv
// One-entry valid/ready holding register; flags results that arrive while full.
module axis_out_reg #(
    parameter int unsigned W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic         ready_i,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    output logic         drop_c_o
);
    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    // A new result is lost only if the held beat is not leaving this cycle.
    assign drop_c_o = load_i & valid_q & ~ready_i;

    // Load when empty or draining, otherwise clear valid on transfer.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i && (!valid_q || ready_i)) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    // Holding register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
endmodule

// File: rtl/axis_decimating_averager.sv
// Averages 2^k signed samples into one output beat; drops and counts results
// when the output is still full. Optional macro: AXIS_AVG_MINMAX_EN.
module axis_decimating_averager
    import axis_avg_pkg::*;
#(
    parameter int unsigned SAXIS_TDATA_WIDTH     = 32,
    parameter int unsigned MAXIS_TDATA_WIDTH     = 32,
    parameter int unsigned MAX_LOG2N             = 15,
    parameter int unsigned configuration_address = 2001
) (
    input  logic                  a_clk,
    input  logic                  a_reset,
    input  logic [CFG_ADDR_W-1:0] config_addr,
    input  logic [CFG_DATA_W-1:0] config_data,
    axis_decimating_averager_if.sink   s_axis,
    axis_decimating_averager_if.master m_axis,
    output logic                  overflow,
    output logic [DROP_CNT_W-1:0] drop_count,
    output logic [WIN_CNT_W-1:0]  window_count
);
    localparam int unsigned SW    = SAXIS_TDATA_WIDTH;
    localparam int unsigned MW    = MAXIS_TDATA_WIDTH;
    localparam int unsigned ACC_W = SW + MAX_LOG2N;
    localparam int unsigned CNT_W = (MAX_LOG2N > 0) ? MAX_LOG2N : 1;
`ifdef AXIS_AVG_MINMAX_EN
    localparam int unsigned PAY_W = MW + 2 * SW;
`else
    localparam int unsigned PAY_W = MW;
`endif

    avg_state_e               state_q;
    logic [LOG2N_W-1:0]       log2n_q;
    logic                     enable_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic [CNT_W-1:0]         cnt_q;
    logic                     overflow_q;
    logic [DROP_CNT_W-1:0]    drop_cnt_q;
    logic [WIN_CNT_W-1:0]     win_cnt_q;

    logic                     cfg_wr_c, accept_c, done_c, drop_c;
    avg_cfg_t                 cfg_c;
    logic [CNT_W-1:0]         win_len_m1_c;
    logic signed [ACC_W-1:0]  sample_ext_c, sum_c;
    logic signed [SW-1:0]     mean_c;
    logic [PAY_W-1:0]         res_pay_c, out_pay;
    logic                     out_valid;
    logic                     unused_cfg_bits;

    assign unused_cfg_bits = ^config_data[CFG_DATA_W-1:CLR_BIT+1];

    assign cfg_wr_c     = (config_addr == CFG_ADDR_W'(configuration_address));
    assign cfg_c        = decode_cfg(config_data[CLR_BIT:0], MAX_LOG2N);
    assign accept_c     = (state_q == ACCUM) && enable_q && !cfg_wr_c && s_axis.tvalid;
    assign win_len_m1_c = CNT_W'((32'd1 << log2n_q) - 32'd1);
    assign done_c       = accept_c && (cnt_q == win_len_m1_c);
    assign sample_ext_c = ACC_W'($signed(s_axis.tdata));
    assign sum_c        = acc_q + sample_ext_c;
    assign mean_c       = SW'(sum_c >>> log2n_q);

`ifdef AXIS_AVG_MINMAX_EN
    logic signed [SW-1:0] sample_c, min_q, max_q, cur_min_c, cur_max_c;
    assign sample_c  = s_axis.tdata;
    // First sample of a window seeds both extremes.
    assign cur_min_c = (cnt_q == '0 || sample_c < min_q) ? sample_c : min_q;
    assign cur_max_c = (cnt_q == '0 || sample_c > max_q) ? sample_c : max_q;
    assign res_pay_c = {cur_max_c, cur_min_c, MW'(mean_c)};

    // Running extremes of the current window.
    always_ff @(posedge a_clk) begin
        if (a_reset) begin
            min_q <= '0;
            max_q <= '0;
        end else if (accept_c) begin
            min_q <= cur_min_c;
            max_q <= cur_max_c;
        end
    end

    assign m_axis.tdata     = out_pay[MW-1:0];
    assign m_axis.min_tdata = out_pay[MW +: SW];
    assign m_axis.max_tdata = out_pay[MW+SW +: SW];
`else
    assign res_pay_c    = MW'(mean_c);
    assign m_axis.tdata = out_pay;
`endif

    // Config capture, IDLE/ACCUM control and window accumulation.
    always_ff @(posedge a_clk) begin
        if (a_reset) begin
            state_q  <= IDLE;
            log2n_q  <= '0;
            enable_q <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable_q) state_q <= ACCUM;
                end
                ACCUM: begin
                    if (!enable_q) begin
                        state_q <= IDLE;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                    end else if (done_c) begin
                        acc_q <= '0;
                        cnt_q <= '0;
                    end else if (accept_c) begin
                        acc_q <= sum_c;
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (cfg_wr_c) begin
                log2n_q  <= cfg_c.log2n;
                enable_q <= cfg_c.enable;
                acc_q    <= '0;
                cnt_q    <= '0;
            end
        end
    end

    axis_out_reg #(.W(PAY_W)) u_out_reg (
        .clk_i    (a_clk),
        .rst_i    (a_reset),
        .load_i   (done_c),
        .data_i   (res_pay_c),
        .ready_i  (m_axis.tready),
        .valid_o  (out_valid),
        .data_o   (out_pay),
        .drop_c_o (drop_c)
    );
    assign m_axis.tvalid = out_valid;

    // Window/drop statistics; a drop overrides a same-cycle clear.
    always_ff @(posedge a_clk) begin
        if (a_reset) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
            win_cnt_q  <= '0;
        end else begin
            if (done_c) win_cnt_q <= win_cnt_q + WIN_CNT_W'(1);
            if (drop_c) begin
                overflow_q <= 1'b1;
                if (cfg_wr_c && cfg_c.clr) drop_cnt_q <= DROP_CNT_W'(1);
                else if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + DROP_CNT_W'(1);
            end else if (cfg_wr_c && cfg_c.clr) begin
                overflow_q <= 1'b0;
                drop_cnt_q <= '0;
            end
        end
    end

    assign overflow     = overflow_q;
    assign drop_count   = drop_cnt_q;
    assign window_count = win_cnt_q;
endmodule
